// File: rtl/s2f_pkg.sv
// Shared definitions for the slow-to-fast multi-channel pulse synchroniser.
// Latency: n/a (constants and a pure combinational helper only).
// Backpressure: n/a.
package s2f_pkg;

  // Which input transitions count as events.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // Legal parameter ranges for the synchroniser top.
  localparam int CHANNELS_MIN    = 1;
  localparam int CHANNELS_MAX    = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int CNT_W_MIN       = 1;
  localparam int CNT_W_MAX       = 8;

  // Edge comparison of the synchronised level against its one-cycle-old copy.
  function automatic logic edge_event(input logic [1:0] mode, input logic cur, input logic prev);
    logic ev;
    ev = 1'b0;
    case (mode)
      EDGE_RISE: ev = cur & ~prev;
      EDGE_FALL: ev = ~cur & prev;
      EDGE_BOTH: ev = cur ^ prev;
      default:   ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/s2f_sync_chan.sv
// One channel: synchroniser chain, edge register, pending-event counter, sticky overflow.
// Latency: input transition to out pulse is SYNC_STAGES+1 clk2 edges; count updates with out.
// Backpressure: evt_ready pops one pending event per cycle; events beyond saturation are dropped and flagged.
module s2f_sync_chan
  import s2f_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int EDGE_MODE   = 0
) (
  input  logic             clk2,
  input  logic             reset,
  input  logic             in_a,
  input  logic             evt_en,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             out,
  output logic             in_sync,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf
);

  localparam logic [1:0]       MODE    = 2'(EDGE_MODE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Metastability chain: stage 0 samples the async input, highest index is the settled level.
  (* async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  logic             prev_q, prev_d;
  logic             out_q, out_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic last;
  logic evt;
  logic inc;
  logic dec;

  assign last = sync_q[SYNC_STAGES-1];

  // Pure shift between stages; nothing may sit between synchroniser flops.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_a};
  end

  // Edge detect, counter and overflow next-state; set of ovf takes priority over clear.
  always_comb begin
    prev_d = last;
    evt    = edge_event(MODE, last, prev_q);
    inc    = evt_en & evt;
    dec    = (cnt_q != '0) & evt_ready;
    out_d  = inc;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q & ~ovf_clr;
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // All channel state clears synchronously on reset.
  always_ff @(posedge clk2) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out       = out_q;
  assign in_sync   = last;
  assign evt_valid = (cnt_q != '0);
  assign evt_cnt   = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/s2f_pulse_sync_mc.sv
// Multi-channel slow-to-fast pulse synchroniser with per-channel pending-event counters.
// Latency: SYNC_STAGES+1 clk2 edges from input sample to out pulse; events suppressed while priming after reset.
// Backpressure: per-channel evt_valid/evt_ready handshake; saturation drops events and sets sticky ovf.
module s2f_pulse_sync_mc
  import s2f_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int EDGE_MODE   = 0
) (
  input  logic                      clk2,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       in_sync,
  output logic [CHANNELS-1:0]       evt_valid,
  input  logic [CHANNELS-1:0]       evt_ready,
  output logic [CHANNELS*CNT_W-1:0] evt_cnt,
  output logic [CHANNELS-1:0]       ovf,
  input  logic [CHANNELS-1:0]       ovf_clr
);

  // Priming lasts until the sync chain and edge register all hold post-reset samples.
  localparam int PRIME_N = SYNC_STAGES + 1;
  localparam int PRIME_W = $clog2(PRIME_N + 1);

  logic [PRIME_W-1:0] prime_q, prime_d;
  logic               evt_en;

  // Count up after reset release and park at PRIME_N, which enables event detection.
  always_comb begin
    evt_en  = (prime_q == PRIME_W'(PRIME_N));
    prime_d = prime_q;
    if (!evt_en) begin
      prime_d = prime_q + PRIME_W'(1);
    end
  end

  // Shared priming counter register.
  always_ff @(posedge clk2) begin
    if (reset) begin
      prime_q <= '0;
    end else begin
      prime_q <= prime_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    s2f_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .EDGE_MODE   (EDGE_MODE)
    ) u_chan (
      .clk2      (clk2),
      .reset     (reset),
      .in_a      (in[i]),
      .evt_en    (evt_en),
      .evt_ready (evt_ready[i]),
      .ovf_clr   (ovf_clr[i]),
      .out       (out[i]),
      .in_sync   (in_sync[i]),
      .evt_valid (evt_valid[i]),
      .evt_cnt   (evt_cnt[i*CNT_W +: CNT_W]),
      .ovf       (ovf[i])
    );
  end

endmodule

// File: tb/tb_s2f_pulse_sync_mc.sv
// Directed bench for s2f_pulse_sync_mc: instance A rising-edge/CNT_W=4, instance B both-edge/CNT_W=2.
// Latency: expected out pulses are queued at drive time for cycle drive+3 and popped by a negedge monitor.
// Backpressure: evt_ready/ovf_clr driven directly per step.
module tb_s2f_pulse_sync_mc;

  logic clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  logic        rst_a, rst_b;
  logic [3:0]  in_a, out_a, in_sync_a, evt_valid_a, rdy_a, ovf_a, clr_a;
  logic [15:0] evt_cnt_a;
  logic [3:0]  in_b, out_b, in_sync_b, evt_valid_b, rdy_b, ovf_b, clr_b;
  logic [7:0]  evt_cnt_b;

  s2f_pulse_sync_mc #(.CHANNELS(4), .SYNC_STAGES(2), .CNT_W(4), .EDGE_MODE(0)) u_a (
    .clk2(clk2), .reset(rst_a), .in(in_a), .out(out_a), .in_sync(in_sync_a),
    .evt_valid(evt_valid_a), .evt_ready(rdy_a), .evt_cnt(evt_cnt_a), .ovf(ovf_a), .ovf_clr(clr_a)
  );

  s2f_pulse_sync_mc #(.CHANNELS(4), .SYNC_STAGES(2), .CNT_W(2), .EDGE_MODE(2)) u_b (
    .clk2(clk2), .reset(rst_b), .in(in_b), .out(out_b), .in_sync(in_sync_b),
    .evt_valid(evt_valid_b), .evt_ready(rdy_b), .evt_cnt(evt_cnt_b), .ovf(ovf_b), .ovf_clr(clr_b)
  );

  typedef struct {
    int dut;
    int ch;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk2) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk2);
  endtask

  // Input driven now is sampled at the next edge; pulse is visible after two more edges.
  task automatic expect_pulse(input int d, input int c);
    exp_t e;
    e.dut = d;
    e.ch  = c;
    e.cyc = cyc + 3;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] pk(input int d, input int c, input int y);
    return (32'(d) << 28) | (32'(c) << 24) | (32'(y) & 32'h00FF_FFFF);
  endfunction

  function automatic logic [31:0] cnt_a(input int ch);
    return 32'(evt_cnt_a[ch*4 +: 4]);
  endfunction

  function automatic logic [31:0] cnt_b(input int ch);
    return 32'(evt_cnt_b[ch*2 +: 2]);
  endfunction

  // Every observed out pulse must match the oldest queued expectation exactly.
  always @(negedge clk2) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        logic bitv;
        exp_t e;
        bitv = (d == 0) ? out_a[c] : out_b[c];
        if (bitv) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", pk(d, c, cyc), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("out_pulse", pk(d, c, cyc), pk(e.dut, e.ch, e.cyc));
          end
        end
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    in_a  = 4'b1000; in_b = 4'b0000;
    rdy_a = 4'b0; rdy_b = 4'b0; clr_a = 4'b0; clr_b = 4'b0;
    tick(3);

    // Reset state
    chk("rst_out_a", 32'(out_a), 0);
    chk("rst_in_sync_a", 32'(in_sync_a), 0);
    chk("rst_valid_a", 32'(evt_valid_a), 0);
    chk("rst_cnt_a", 32'(evt_cnt_a), 0);
    chk("rst_ovf_a", 32'(ovf_a), 0);
    chk("rst_cnt_b", 32'(evt_cnt_b), 0);
    chk("rst_valid_b", 32'(evt_valid_b), 0);

    rst_a = 1'b0; rst_b = 1'b0;
    tick(6);
    // Level high through reset release: synchronised but no event
    chk("held_level_sync", 32'(in_sync_a), 32'h8);
    chk("held_level_cnt", 32'(evt_cnt_a), 0);

    // Single slow-period pulse on ch0, then consume it
    in_a[0] = 1'b1; expect_pulse(0, 0);
    tick(2); in_a[0] = 1'b0;
    tick(4);
    chk("single_cnt0", cnt_a(0), 1);
    chk("single_valid", 32'(evt_valid_a), 32'h1);
    rdy_a[0] = 1'b1; tick(1); rdy_a[0] = 1'b0;
    chk("consume_cnt0", cnt_a(0), 0);
    chk("consume_valid", 32'(evt_valid_a), 0);

    // Held-high ch3 falls then rises: exactly one event
    in_a[3] = 1'b0; tick(2);
    in_a[3] = 1'b1; expect_pulse(0, 3);
    tick(5);
    chk("fall_rise_cnt3", cnt_a(3), 1);

    // Event coincident with consume at count 1
    in_a[1] = 1'b1; expect_pulse(0, 1);
    tick(2); in_a[1] = 1'b0;
    tick(4);
    chk("pre_coinc_cnt1", cnt_a(1), 1);
    in_a[1] = 1'b1; expect_pulse(0, 1);
    tick(2); in_a[1] = 1'b0; rdy_a[1] = 1'b1;
    tick(1); rdy_a[1] = 1'b0;
    chk("coinc_cnt1", cnt_a(1), 1);
    chk("indep_cnt3", cnt_a(3), 1);
    rdy_a[1] = 1'b1; tick(1); rdy_a[1] = 1'b0;
    chk("drain_cnt1", cnt_a(1), 0);

    // Mid-operation reset with count 2 and an edge in flight
    in_a[0] = 1'b1; expect_pulse(0, 0);
    tick(2); in_a[0] = 1'b0;
    tick(2); in_a[0] = 1'b1; expect_pulse(0, 0);
    tick(2); in_a[0] = 1'b0;
    tick(4);
    chk("pre_rst_cnt0", cnt_a(0), 2);
    in_a[0] = 1'b1;
    tick(1); rst_a = 1'b1;
    tick(1);
    chk("midrst_out", 32'(out_a), 0);
    chk("midrst_cnt", 32'(evt_cnt_a), 0);
    chk("midrst_valid", 32'(evt_valid_a), 0);
    chk("midrst_in_sync", 32'(in_sync_a), 0);
    chk("midrst_ovf", 32'(ovf_a), 0);
    tick(1); rst_a = 1'b0;
    tick(8);
    chk("post_rst_cnt", 32'(evt_cnt_a), 0);
    chk("post_rst_sync", 32'(in_sync_a), 32'h9);
    in_a = 4'b0000;
    tick(4);

    // Both-edge mode: rise and fall on ch1 give two events
    in_b[1] = 1'b1; expect_pulse(1, 1);
    tick(4); in_b[1] = 1'b0; expect_pulse(1, 1);
    tick(6);
    chk("both_cnt1", cnt_b(1), 2);
    chk("both_others", 32'(evt_cnt_b & 8'hF3), 0);
    chk("both_valid", 32'(evt_valid_b), 32'h2);

    // Saturation on ch2 with CNT_W=2
    for (int i = 0; i < 4; i++) begin
      in_b[2] = ~in_b[2]; expect_pulse(1, 2);
      tick(2);
    end
    tick(4);
    chk("sat_cnt2", cnt_b(2), 3);
    chk("sat_ovf", 32'(ovf_b), 32'h4);
    clr_b[2] = 1'b1; tick(1); clr_b[2] = 1'b0;
    chk("clr_ovf", 32'(ovf_b), 0);
    chk("clr_cnt2", cnt_b(2), 3);

    // Event plus consume at saturation: count held, no overflow
    in_b[2] = 1'b1; expect_pulse(1, 2);
    tick(2); rdy_b[2] = 1'b1;
    tick(1); rdy_b[2] = 1'b0;
    chk("sat_coinc_cnt2", cnt_b(2), 3);
    chk("sat_coinc_ovf", 32'(ovf_b), 0);

    // Overflow and clear in the same cycle: set wins
    in_b[2] = 1'b0; expect_pulse(1, 2);
    tick(2); clr_b[2] = 1'b1;
    tick(1); clr_b[2] = 1'b0;
    chk("set_wins_ovf", 32'(ovf_b), 32'h4);
    chk("set_wins_cnt2", cnt_b(2), 3);

    // Ready with nothing pending is ignored
    rdy_b[0] = 1'b1; tick(2); rdy_b[0] = 1'b0;
    chk("no_underflow_cnt0", cnt_b(0), 0);
    chk("no_underflow_valid0", 32'(evt_valid_b[0]), 0);
    rdy_b[2] = 1'b1; tick(3); rdy_b[2] = 1'b0;
    chk("drain_cnt2", cnt_b(2), 0);
    chk("drain_keeps_cnt1", cnt_b(1), 2);

    tick(6);
    chk("pulses_left", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/s2f_pulse_sync_mc.md
S2F_PULSE_SYNC_MC -- requirements
Module: s2f_pulse_sync_mc

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent slow-domain inputs, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flop depth, 2..4.
REQ-003 Parameter CNT_W, default 4: per-channel pending-event counter width, 1..8.
REQ-004 Parameter EDGE_MODE, default 0: events detected; 0 = rising, 1 = falling, 2 = both.
REQ-005 clk2  input  1  destination (fast) clock; the block's only clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in  input  CHANNELS  asynchronous pulses/levels from the slow domain.
REQ-008 out  output  CHANNELS  one-clk2-cycle pulse per detected event.
REQ-009 in_sync  output  CHANNELS  synchronised level of in (last sync stage).
REQ-010 evt_valid  output  CHANNELS  high while the channel's pending count is non-zero.
REQ-011 evt_ready  input  CHANNELS  consumer acknowledge; one event consumed per cycle when valid and ready are both high.
REQ-012 evt_cnt  output  CHANNELS*CNT_W  pending count per channel; channel i at bits [i*CNT_W +: CNT_W].
REQ-013 ovf  output  CHANNELS  sticky flag: an event was dropped at saturation.
REQ-014 ovf_clr  input  CHANNELS  clears the matching ovf bit.

Function
REQ-015 Each in bit SHALL pass through SYNC_STAGES flops clocked by clk2 before any other logic uses it.
REQ-016 An edge reg prev SHALL hold the last sync stage delayed by one cycle; an event is the EDGE_MODE-selected comparison of last stage against prev.
REQ-017 out SHALL be registered; an in transition sampled at clk2 edge k SHALL produce out high for exactly the cycle following edge k+SYNC_STAGES (latency SYNC_STAGES+1 edges).
REQ-018 An in high for at least one clk2 period and low for at least one SHALL yield exactly one rising event; holding in high for any duration SHALL NOT yield additional events.
REQ-019 Pending count SHALL increment on the edge on which out is asserted and decrement on a valid-and-ready cycle.
REQ-020 Simultaneous event and consume SHALL leave the count unchanged.
REQ-021 Event at count = 2^CNT_W-1 without simultaneous consume: count held, ovf set; with simultaneous consume: count held, ovf not set.
REQ-022 evt_ready while evt_valid is low SHALL be ignored; count never underflows.
REQ-023 ovf_clr and a new overflow in the same cycle: ovf SHALL remain set (set wins).
REQ-024 Priming: for SYNC_STAGES+1 cycles after reset deasserts, prev SHALL track the last stage while events, out and count updates are suppressed; a level already high at reset release produces no event.
REQ-025 Channels SHALL be fully independent; activity on one never alters another's outputs.

Reset
REQ-026 While reset is high at a clk2 edge, all sync stages, prev, out, evt_cnt, ovf and the priming counter SHALL clear to 0; evt_valid and in_sync SHALL read 0 in the following cycle.
REQ-027 Reset asserted mid-operation SHALL discard pending counts and in-flight sync-chain contents, then restart priming per REQ-024.

Structure
REQ-028 Package s2f_pkg SHALL hold the EDGE_MODE encodings (EDGE_RISE = 0, EDGE_FALL = 1, EDGE_BOTH = 2) and the parameter range limits.
REQ-029 Per-channel logic (sync chain, edge reg, counter, ovf) SHALL live in sub-module s2f_sync_chan, instantiated CHANNELS times by generate; the priming counter is shared at top level.
REQ-030 Sync-chain flops SHALL carry the team's synchroniser attribute; no logic between stages.

Verification (clk2 100 MHz, slow source 50 MHz)
REQ-031 Reset 2 cycles, in[0] high for one 20 ns slow period -> out[0] single 10 ns pulse 3 edges after sampling (SYNC_STAGES=2), evt_cnt[0]=1, evt_valid[0]=1; evt_ready[0] one cycle -> count 0.
REQ-032 EDGE_MODE=2, in[1] toggles 0->1->0 with 40 ns spacing -> two out[1] pulses, evt_cnt[1]=2; other channels stay 0.
REQ-033 CNT_W=2, 4 events on ch2 with evt_ready low -> count saturates at 3, ovf[2]=1; ovf_clr[2] -> ovf[2]=0, count still 3.
REQ-034 Event and evt_ready coincide at count 1 -> count stays 1; at count 3 (CNT_W=2) -> count 3, ovf unchanged.
REQ-035 in[3] held high through reset release -> no out pulse, count 0; later fall then rise -> exactly one event.
REQ-036 reset asserted with evt_cnt[0]=2 and an edge in the sync chain -> all outputs 0 next cycle, no event emitted after release.
